// File: rtl/tile_match_ctrl.sv
// Turn sequencer for the tile-matching game: synchronises the keys, walks each turn
// through two picks, a timed reveal and match resolution, and keeps masks/score/tries.
module tile_match_ctrl #(
    parameter  int NUM_TILES   = 8,
    parameter  int VAL_W       = 3,
    parameter  int SHOW_CYCLES = 50_000_000,
    localparam int IDX_W       = $clog2(NUM_TILES),
    localparam int SCORE_W     = $clog2(NUM_TILES / 2 + 1)
) (
    input  logic                 CLOCK_50,
    input  logic                 resetn,
    input  logic                 start_n,
    input  logic                 pick_n,
    input  logic [IDX_W-1:0]     sel,
    output logic [IDX_W-1:0]     mem_addr,
    input  logic [VAL_W-1:0]     mem_data,
    output logic [NUM_TILES-1:0] revealed,
    output logic [NUM_TILES-1:0] matched,
    output logic [SCORE_W-1:0]   score,
    output logic [7:0]           tries,
    output logic                 reject,
    output logic                 game_over
);

    localparam int CNT_W = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_PICK1, S_READ1, S_PICK2, S_READ2, S_SHOW, S_DONE
    } state_t;

    state_t               r_state, w_next_state;
    logic [1:0]           r_start_sync, r_pick_sync;
    logic                 r_start_prev, r_pick_prev;
    logic [IDX_W-1:0]     r_idx1, r_idx2, r_mem_addr;
    logic [VAL_W-1:0]     r_val1;
    logic [NUM_TILES-1:0] r_revealed, r_matched;
    logic [SCORE_W-1:0]   r_score;
    logic [7:0]           r_tries;
    logic                 r_reject;
    logic [CNT_W-1:0]     r_cnt;

    logic w_start_pulse, w_pick_pulse, w_sel_valid;
    logic w_clear, w_take, w_reject, w_capture, w_resolve, w_game_over;

    // Synchronisers idle at 1 (key released) so reset never looks like a press.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_start_sync <= 2'b11;
            r_pick_sync  <= 2'b11;
            r_start_prev <= 1'b1;
            r_pick_prev  <= 1'b1;
        end else begin
            // NOTE: non-blocking so every stage samples the previous stage's old value.
            r_start_sync <= {r_start_sync[0], start_n};
            r_pick_sync  <= {r_pick_sync[0], pick_n};
            r_start_prev <= r_start_sync[1];
            r_pick_prev  <= r_pick_sync[1];
        end
    end

    assign w_start_pulse = r_start_prev & ~r_start_sync[1];
    assign w_pick_pulse  = r_pick_prev & ~r_pick_sync[1];

    assign w_sel_valid = (32'(sel) < NUM_TILES) && !r_matched[sel]
                         && !((r_state == S_PICK2) && (sel == r_idx1));

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_next_state;
    end

    always_comb begin
        // NOTE: default assignment first so no path leaves the signal unassigned (no latch).
        w_next_state = r_state;
        case (r_state)
            S_IDLE, S_DONE: if (w_start_pulse) w_next_state = S_PICK1;
            S_PICK1:        if (w_take) w_next_state = S_READ1;
            S_READ1:        w_next_state = S_PICK2;
            S_PICK2:        if (w_take) w_next_state = S_READ2;
            S_READ2:        w_next_state = S_SHOW;
            S_SHOW: begin
                if (r_cnt == '0)
                    w_next_state = (r_matched == '1) ? S_DONE : S_PICK1;
            end
            default:        w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        w_clear     = 1'b0;
        w_take      = 1'b0;
        w_reject    = 1'b0;
        w_capture   = 1'b0;
        w_resolve   = 1'b0;
        w_game_over = 1'b0;
        case (r_state)
            S_IDLE:  w_clear = w_start_pulse;
            S_PICK1, S_PICK2: begin
                w_take   = w_pick_pulse & w_sel_valid;
                w_reject = w_pick_pulse & ~w_sel_valid;
            end
            S_READ1: w_capture = 1'b1;
            S_READ2: w_resolve = 1'b1;
            S_DONE: begin
                w_game_over = 1'b1;
                w_clear     = w_start_pulse;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_idx1     <= '0;
            r_idx2     <= '0;
            r_mem_addr <= '0;
            r_val1     <= '0;
            r_revealed <= '0;
            r_matched  <= '0;
            r_score    <= '0;
            r_tries    <= '0;
            r_reject   <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_reject <= w_reject;
            if (w_clear) begin
                r_revealed <= '0;
                r_matched  <= '0;
                r_score    <= '0;
                r_tries    <= '0;
            end
            if (w_take) begin
                r_mem_addr      <= sel;
                r_revealed[sel] <= 1'b1;
                if (r_state == S_PICK1) r_idx1 <= sel;
                else                    r_idx2 <= sel;
            end
            if (w_capture) r_val1 <= mem_data;
            if (w_resolve) begin
                if (mem_data == r_val1) begin
                    r_matched[r_idx1] <= 1'b1;
                    r_matched[r_idx2] <= 1'b1;
                    r_score           <= r_score + SCORE_W'(1);
                end
                if (r_tries != 8'hFF) r_tries <= r_tries + 8'd1;
                r_cnt <= CNT_W'(SHOW_CYCLES - 1);
            end else if (r_state == S_SHOW) begin
                if (r_cnt == '0) r_revealed <= '0;
                else             r_cnt      <= r_cnt - CNT_W'(1);
            end
        end
    end

    // The pick address goes straight out so a registered board memory returns data in READx.
    assign mem_addr  = w_take ? sel : r_mem_addr;
    assign revealed  = r_revealed;
    assign matched   = r_matched;
    assign score     = r_score;
    assign tries     = r_tries;
    assign reject    = r_reject;
    assign game_over = w_game_over;

endmodule

// File: tb/tb_tile_match_ctrl.sv
// Directed bench for tile_match_ctrl: plays scripted turns against a small registered
// board memory and checks masks, score, tries, reject pulses and game_over.
module tb_tile_match_ctrl;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       start_n = 1'b1;
    logic       pick_n = 1'b1;
    logic [2:0] sel = 3'd0;
    logic [2:0] mem_addr;
    logic [2:0] mem_data = 3'd0;
    logic [7:0] revealed, matched;
    logic [2:0] score;
    logic [7:0] tries;
    logic       reject, game_over;

    logic [2:0] board [8];
    int n_assert = 0;
    int n_fail   = 0;
    int rej_cnt  = 0;
    int rej_base = 0;

    tile_match_ctrl #(.NUM_TILES(8), .VAL_W(3), .SHOW_CYCLES(4)) dut (
        .CLOCK_50 (clk),
        .resetn   (resetn),
        .start_n  (start_n),
        .pick_n   (pick_n),
        .sel      (sel),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .revealed (revealed),
        .matched  (matched),
        .score    (score),
        .tries    (tries),
        .reject   (reject),
        .game_over(game_over)
    );

    always #5 clk = ~clk;

    always @(posedge clk) mem_data <= board[mem_addr];

    always @(negedge clk) if (reject === 1'b1) rej_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Press held 4 clocks, then released 3 clocks so the synchroniser sees the release.
    task automatic do_pick(input logic [2:0] idx);
        @(negedge clk);
        sel    = idx;
        pick_n = 1'b0;
        repeat (4) @(negedge clk);
        pick_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic do_start();
        @(negedge clk);
        start_n = 1'b0;
        repeat (4) @(negedge clk);
        start_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        board[0] = 3'd3; board[1] = 3'd3; board[2] = 3'd5; board[3] = 3'd6;
        board[4] = 3'd5; board[5] = 3'd6; board[6] = 3'd1; board[7] = 3'd1;

        repeat (3) @(negedge clk);
        check("rst_revealed", 32'(revealed), 32'h00);
        check("rst_matched", 32'(matched), 32'h00);
        check("rst_score", 32'(score), 32'd0);
        check("rst_tries", 32'(tries), 32'd0);
        check("rst_reject", 32'(reject), 32'd0);
        check("rst_game_over", 32'(game_over), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        resetn = 1'b1;

        // Turn 1: tiles 0,1 match (3,3).
        do_start();
        do_pick(3'd0);
        do_pick(3'd1);
        check("t1_revealed_show", 32'(revealed), 32'h03);
        check("t1_matched", 32'(matched), 32'h03);
        check("t1_score", 32'(score), 32'd1);
        check("t1_tries", 32'(tries), 32'd1);
        @(negedge clk);
        check("t1_revealed_clear", 32'(revealed), 32'h00);

        // Turn 2: tiles 2,3 mismatch (5,6).
        do_pick(3'd2);
        do_pick(3'd3);
        check("t2_revealed_show", 32'(revealed), 32'h0C);
        check("t2_matched", 32'(matched), 32'h03);
        check("t2_score", 32'(score), 32'd1);
        check("t2_tries", 32'(tries), 32'd2);
        @(negedge clk);
        check("t2_revealed_clear", 32'(revealed), 32'h00);

        // Turn 3: same-tile and matched-tile picks rejected in PICK2, then 2,4 match.
        do_pick(3'd2);
        rej_base = rej_cnt;
        do_pick(3'd2);
        do_pick(3'd0);
        check("rej_count", 32'(rej_cnt - rej_base), 32'd2);
        check("rej_revealed", 32'(revealed), 32'h04);
        check("rej_matched", 32'(matched), 32'h03);
        do_pick(3'd4);
        check("t3_matched", 32'(matched), 32'h17);
        check("t3_score", 32'(score), 32'd2);
        check("t3_tries", 32'(tries), 32'd3);
        check("t3_revealed_show", 32'(revealed), 32'h14);
        @(negedge clk);

        // Turn 4: pick key held 20 clocks gives one pick only; then 3,5 match.
        rej_base = rej_cnt;
        @(negedge clk);
        sel    = 3'd3;
        pick_n = 1'b0;
        repeat (20) @(negedge clk);
        pick_n = 1'b1;
        repeat (3) @(negedge clk);
        check("hold_revealed", 32'(revealed), 32'h08);
        check("hold_no_reject", 32'(rej_cnt - rej_base), 32'd0);
        do_pick(3'd5);
        check("t4_matched", 32'(matched), 32'h3F);
        check("t4_score", 32'(score), 32'd3);
        check("t4_tries", 32'(tries), 32'd4);
        @(negedge clk);

        // Turn 5: last pair 6,7.
        do_pick(3'd6);
        do_pick(3'd7);
        check("t5_matched", 32'(matched), 32'hFF);
        check("t5_score", 32'(score), 32'd4);
        check("t5_tries", 32'(tries), 32'd5);
        check("t5_game_over_show", 32'(game_over), 32'd0);
        @(negedge clk);
        check("t5_game_over", 32'(game_over), 32'd1);
        check("t5_revealed_clear", 32'(revealed), 32'h00);

        // Picks in DONE are dropped without reject.
        rej_base = rej_cnt;
        do_pick(3'd0);
        check("done_no_reject", 32'(rej_cnt - rej_base), 32'd0);
        check("done_matched", 32'(matched), 32'hFF);
        check("done_game_over", 32'(game_over), 32'd1);

        // Restart from DONE.
        do_start();
        check("restart_matched", 32'(matched), 32'h00);
        check("restart_score", 32'(score), 32'd0);
        check("restart_tries", 32'(tries), 32'd0);
        check("restart_game_over", 32'(game_over), 32'd0);

        // Reset while in SHOW.
        do_pick(3'd0);
        do_pick(3'd1);
        check("pre_rst_matched", 32'(matched), 32'h03);
        resetn = 1'b0;
        #1;
        check("midrst_revealed", 32'(revealed), 32'h00);
        check("midrst_matched", 32'(matched), 32'h00);
        check("midrst_score", 32'(score), 32'd0);
        check("midrst_tries", 32'(tries), 32'd0);
        check("midrst_mem_addr", 32'(mem_addr), 32'd0);
        check("midrst_game_over", 32'(game_over), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        rej_base = rej_cnt;
        do_pick(3'd2);
        check("idle_pick_revealed", 32'(revealed), 32'h00);
        check("idle_pick_reject", 32'(rej_cnt - rej_base), 32'd0);
        check("idle_pick_mem_addr", 32'(mem_addr), 32'd0);
        do_start();
        do_pick(3'd2);
        do_pick(3'd4);
        check("post_rst_matched", 32'(matched), 32'h14);
        check("post_rst_score", 32'(score), 32'd1);
        check("post_rst_tries", 32'(tries), 32'd1);

        // 255 more mismatching turns: tries must saturate at 255.
        for (int i = 0; i < 255; i++) begin
            do_pick(3'd0);
            do_pick(3'd3);
        end
        check("sat_tries", 32'(tries), 32'd255);
        check("sat_score", 32'(score), 32'd1);
        check("sat_matched", 32'(matched), 32'h14);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/tile_match_ctrl.md
# tile_match_ctrl

Turn sequencer for the tile-matching game. Takes the player's tile selection (SW) and the pick/start keys, reads tile face values from the board memory, and walks each turn through first pick, second pick, timed reveal and match resolution. Maintains the revealed/matched masks, pair score and try counter consumed by the LEDR/HEX display logic in `tilegame`.

## Interface

- `NUM_TILES`, 8: tiles on the board; even; 2..16.
- `VAL_W`, 3: width of a tile face value.
- `SHOW_CYCLES`, 50_000_000: reveal hold time in clocks (1 s at 50 MHz); benches use 4.
- `CLOCK_50`  in  1  system clock.
- `resetn`  in  1  asynchronous active-low reset (KEY[0] at top level).
- `start_n`  in  1  start key, active-low level (KEY[1]).
- `pick_n`  in  1  pick key, active-low level (KEY[2]).
- `sel`  in  $clog2(NUM_TILES)  tile index from SW.
- `mem_addr`  out  $clog2(NUM_TILES)  board memory read address.
- `mem_data`  in  VAL_W  face value; valid one cycle after `mem_addr`.
- `revealed`  out  NUM_TILES  tiles currently face-up in this turn.
- `matched`  out  NUM_TILES  tiles permanently matched.
- `score`  out  $clog2(NUM_TILES/2+1)  pairs found.
- `tries`  out  8  completed turns, saturating at 255.
- `reject`  out  1  one-cycle pulse: pick ignored.
- `game_over`  out  1  high in DONE.

## Operation

- `start_n` and `pick_n` each pass through a 2-flop synchronizer; a press is a one-cycle pulse on synced 1->0 transition. Holding a key gives one pulse.
- States: IDLE, PICK1, READ1, PICK2, READ2, SHOW, DONE.
- IDLE: start pulse -> clear `matched`, `revealed`, `score`, `tries`; go PICK1.
- PICK1: pick pulse with valid `sel` -> latch `idx1=sel`, drive `mem_addr=sel`, set `revealed[sel]`; go READ1.
- READ1: capture `val1=mem_data`; go PICK2.
- PICK2: pick pulse with valid `sel` -> latch `idx2`, `mem_addr=sel`, set `revealed[sel]`; go READ2.
- READ2: compare `mem_data` with `val1`. Equal: set `matched[idx1]`, `matched[idx2]`, `score+1`. Always `tries+1` (saturate). Load reveal counter with SHOW_CYCLES-1; go SHOW.
- SHOW: count down; at 0 clear `revealed`; go DONE if `matched` all ones, else PICK1.
- DONE: `game_over=1`; start pulse restarts exactly as from IDLE.
- Valid `sel`: `sel < NUM_TILES`, `matched[sel]==0`, and in PICK2 `sel != idx1`. Invalid pick -> `reject` pulse, no state or mask change.
- Pick pulses outside PICK1/PICK2 are dropped silently (no `reject`). Start pulses outside IDLE/DONE are ignored.
- `mem_addr` holds last driven value between reads.

## Timing

- Reset (async assert, sync-free deassert OK): state IDLE; all outputs 0; counters 0; synchronizers reset to 1 (released).
- Key press to pulse: 2-3 clocks after `pick_n` falls (sync depth + edge).
- Pick pulse cycle in PICK2 -> `revealed` bit visible next edge; `score`/`matched`/`tries` update at end of READ2 (2 cycles after pulse).
- SHOW lasts exactly SHOW_CYCLES clocks; `revealed` clears on the edge leaving SHOW.
- Last pair: `game_over` rises SHOW_CYCLES+1 clocks after READ2.
- Reset mid-turn (any state): immediate return to IDLE, masks cleared, partial turn discarded.
- Start and pick pulses in same cycle: start wins in IDLE/DONE, pick wins in PICK1/PICK2.

## Test plan

- Reset then start, pick 0, pick 1 with mem values 3,3 -> `matched=8'b00000011`, `score=1`, `tries=1`, `revealed` 0 after 4 SHOW clocks.
- Pick 2, pick 3 with values 5,6 -> `matched` unchanged, `score=1`, `tries=2`, `revealed=8'b00001100` during SHOW then 0.
- In PICK2 pick same tile as first, then pick a matched tile -> two `reject` pulses, state stays PICK2, masks unchanged.
- Match all 4 pairs -> `score=4`, `matched=8'hFF`, `game_over=1`; start press -> all cleared, state PICK1.
- Hold `pick_n` low 20 clocks in PICK1 -> exactly one pick accepted.
- Assert `resetn` low during SHOW -> all outputs 0 immediately, state IDLE; picks ignored until start.
